// File: rtl/ringbuf_chk_pkg.sv
// Shared types and constants for the ringbuf receive-side PRBS checker.
package ringbuf_chk_pkg;

    localparam int unsigned PRBS_W = 20;
    localparam int unsigned TAP_A  = 2;
    localparam int unsigned TAP_B  = 19;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // Increment v by one unless it already sits at max_v.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ringbuf_err_window.sv
// Error-monitoring window: counts strobes and errors while locked, flags loss and wrap.
module ringbuf_err_window #(
    parameter int unsigned WIN_LEN     = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic err,
    input  logic clr,
    output logic loss_c,
    output logic wrap_c
);

    localparam int unsigned WC_W = $clog2(WIN_LEN + 1);
    localparam int unsigned WE_W = $clog2(LOSS_THRESH + 1);

    logic [WC_W-1:0] win_cnt;
    logic [WE_W-1:0] win_err;

    assign loss_c = en && err && (win_err == WE_W'(LOSS_THRESH - 1));
    assign wrap_c = en && (win_cnt == WC_W'(WIN_LEN - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (clr) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (en) begin
            win_cnt <= win_cnt + 1'b1;
            if (err) begin
                win_err <= win_err + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ringbuf_rx_checker.sv
// Receive-side PRBS checker: locks an x^20+x^3+1 XNOR LFSR to rxda, counts errors, detects sync loss.
module ringbuf_rx_checker
    import ringbuf_chk_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 32,
    parameter int unsigned WIN_LEN     = 64,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rxda,
    input  logic             outstrobe,
    input  logic             clr_counts,
    output logic             locked,
    output logic             dataerror,
    output logic             sync_loss,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned FILL_W = $clog2(PRBS_W + 1);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chk_state_e        state_q, state_d;
    logic [PRBS_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              locked_d, dataerror_d, sync_loss_d;
    logic [CNT_W-1:0]  err_d, bit_d;

    logic pred_c, mismatch_c, win_en_c, win_clr_c, loss_c, wrap_c;

    assign pred_c     = hist_q[TAP_A] ~^ hist_q[TAP_B];
    assign mismatch_c = rxda ^ pred_c;
    assign win_en_c   = outstrobe && (state_q == LOCKED);
    assign win_clr_c  = loss_c || wrap_c;

    ringbuf_err_window #(
        .WIN_LEN    (WIN_LEN),
        .LOSS_THRESH(LOSS_THRESH)
    ) u_win (
        .clock (clock),
        .reset (reset),
        .en    (win_en_c),
        .err   (mismatch_c),
        .clr   (win_clr_c),
        .loss_c(loss_c),
        .wrap_c(wrap_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= FILL;
            hist_q    <= '0;
            fill_q    <= '0;
            good_q    <= '0;
            locked    <= 1'b0;
            dataerror <= 1'b0;
            sync_loss <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            good_q    <= good_d;
            locked    <= locked_d;
            dataerror <= dataerror_d;
            sync_loss <= sync_loss_d;
            err_count <= err_d;
            bit_count <= bit_d;
        end
    end

    // Next-state and output logic; nothing but the pulses moves without a strobe.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        good_d      = good_q;
        locked_d    = locked;
        dataerror_d = 1'b0;
        sync_loss_d = 1'b0;
        err_d       = err_count;
        bit_d       = bit_count;

        if (outstrobe) begin
            unique case (state_q)
                FILL: begin
                    hist_d = {hist_q[PRBS_W-2:0], rxda};
                    if (fill_q == FILL_W'(PRBS_W - 1)) begin
                        state_d = HUNT;
                        fill_d  = '0;
                        good_d  = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                HUNT: begin
                    hist_d = {hist_q[PRBS_W-2:0], rxda};
                    // All-ones history is the XNOR lockup state and never counts as good.
                    if (!mismatch_c && (hist_q != '1)) begin
                        if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            good_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running reference so a single line error is counted once.
                    hist_d = {hist_q[PRBS_W-2:0], pred_c};
                    bit_d  = CNT_W'(sat_inc(32'(bit_count), 32'(CNT_MAX)));
                    if (mismatch_c) begin
                        dataerror_d = 1'b1;
                        err_d       = CNT_W'(sat_inc(32'(err_count), 32'(CNT_MAX)));
                    end
                    if (loss_c) begin
                        state_d     = FILL;
                        locked_d    = 1'b0;
                        sync_loss_d = 1'b1;
                        fill_d      = '0;
                    end
                end
                default: begin
                    state_d  = FILL;
                    locked_d = 1'b0;
                    fill_d   = '0;
                end
            endcase
        end

        if (clr_counts) begin
            err_d = '0;
            bit_d = '0;
        end
    end

endmodule

// File: tb/tb_ringbuf_rx_checker.sv
// Self-checking bench for ringbuf_rx_checker: behavioural model feeds a scoreboard, plus directed checks.
module tb_ringbuf_rx_checker;

    localparam int unsigned CW   = 7;
    localparam int          SATV = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          rxda;
    logic          outstrobe;
    logic          clr_counts;
    logic          locked;
    logic          dataerror;
    logic          sync_loss;
    logic [CW-1:0] err_count;
    logic [CW-1:0] bit_count;

    ringbuf_rx_checker #(
        .LOCK_COUNT (32),
        .WIN_LEN    (64),
        .LOSS_THRESH(8),
        .CNT_W      (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rxda      (rxda),
        .outstrobe (outstrobe),
        .clr_counts(clr_counts),
        .locked    (locked),
        .dataerror (dataerror),
        .sync_loss (sync_loss),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic          lk;
        logic          de;
        logic          sl;
        logic [CW-1:0] ec;
        logic [CW-1:0] bc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_de  = 0;

    logic [19:0] gen = 20'h0;

    // Reference model state
    int          m_phase;
    logic [19:0] m_h;
    int          m_n;
    int          m_wc;
    int          m_we;
    logic        m_lk;
    int          m_ec;
    int          m_bc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_h = '0; m_n = 0; m_wc = 0; m_we = 0;
        m_lk = 1'b0; m_ec = 0; m_bc = 0;
    endtask

    task automatic model_step(input logic d, input logic s, input logic c);
        logic p;
        logic de;
        logic sl;
        de = 1'b0;
        sl = 1'b0;
        p  = ~(m_h[2] ^ m_h[19]);
        if (s) begin
            if (m_phase == 0) begin
                m_h = {m_h[18:0], d};
                m_n++;
                if (m_n == 20) begin m_phase = 1; m_n = 0; end
            end else if (m_phase == 1) begin
                if (d == p && m_h != 20'hFFFFF) m_n++;
                else m_n = 0;
                m_h = {m_h[18:0], d};
                if (m_n == 32) begin
                    m_phase = 2; m_lk = 1'b1; m_n = 0; m_wc = 0; m_we = 0;
                end
            end else begin
                m_h = {m_h[18:0], p};
                if (m_bc < SATV) m_bc++;
                m_wc++;
                if (d != p) begin
                    de = 1'b1;
                    if (m_ec < SATV) m_ec++;
                    m_we++;
                end
                if (m_we == 8) begin
                    sl = 1'b1; m_lk = 1'b0; m_phase = 0; m_n = 0; m_wc = 0; m_we = 0;
                end else if (m_wc == 64) begin
                    m_wc = 0; m_we = 0;
                end
            end
        end
        if (c) begin m_ec = 0; m_bc = 0; end
        sb.push_back({m_lk, de, sl, CW'(m_ec), CW'(m_bc)});
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check("locked",    32'(locked),    32'(e.lk));
        check("dataerror", 32'(dataerror), 32'(e.de));
        check("sync_loss", 32'(sync_loss), 32'(e.sl));
        check("err_count", 32'(err_count), 32'(e.ec));
        check("bit_count", 32'(bit_count), 32'(e.bc));
        if (dataerror === 1'b1) n_de++;
    endtask

    task automatic drive(input logic d, input logic s, input logic c);
        @(negedge clock);
        rxda = d; outstrobe = s; clr_counts = c;
        model_step(d, s, c);
        @(posedge clock);
        #1;
        compare_out();
    endtask

    task automatic send(input logic inv, input logic c);
        logic b;
        b   = gen[2] ~^ gen[19];
        gen = {gen[18:0], b};
        drive(b ^ inv, 1'b1, c);
    endtask

    task automatic gap();
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; outstrobe = 1'b0; clr_counts = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic lock_up(input string tag);
        for (int i = 1; i <= 52; i++) begin
            send(1'b0, 1'b0);
            if (i == 51) check({tag, "_prelock"}, 32'(locked), 32'd0);
        end
        check({tag, "_lock52"}, 32'(locked), 32'd1);
    endtask

    initial begin
        logic any_lock;
        reset = 1'b0; rxda = 1'b0; outstrobe = 1'b0; clr_counts = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        check("rst_locked", 32'(locked),    32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_bitcnt", 32'(bit_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Clean stream, strobe every cycle, then saturation of bit_count
        lock_up("clean");
        repeat (100) send(1'b0, 1'b0);
        check("clean_bit100", 32'(bit_count), 32'd100);
        check("clean_err0",   32'(err_count), 32'd0);
        repeat (40) send(1'b0, 1'b0);
        check("bit_sat", 32'(bit_count), 32'(SATV));

        // Gapped strobes
        do_reset();
        for (int i = 1; i <= 52; i++) begin
            send(1'b0, 1'b0);
            if (i == 51) check("gap_prelock", 32'(locked), 32'd0);
            repeat ($urandom_range(1, 3)) gap();
        end
        check("gap_lock52", 32'(locked), 32'd1);
        send(1'b1, 1'b0);
        check("gap_err_pulse", 32'(dataerror), 32'd1);
        gap();
        check("gap_pulse_drop", 32'(dataerror), 32'd0);
        check("gap_errcnt_hold", 32'(err_count), 32'd1);

        // Single inverted bit: exactly one error, lock held
        do_reset();
        lock_up("single");
        repeat (10) send(1'b0, 1'b0);
        n_de = 0;
        send(1'b1, 1'b0);
        repeat (30) send(1'b0, 1'b0);
        check("single_pulses", 32'(n_de),      32'd1);
        check("single_errcnt", 32'(err_count), 32'd1);
        check("single_locked", 32'(locked),    32'd1);

        // Eight errors within a window force sync loss, then relock after 52 strobes
        do_reset();
        lock_up("loss");
        for (int i = 1; i <= 15; i++) begin
            send(((i % 2) == 1) ? 1'b1 : 1'b0, 1'b0);
            if (i == 13) check("loss_pre_locked", 32'(locked), 32'd1);
        end
        check("loss_pulse",  32'(sync_loss), 32'd1);
        check("loss_locked", 32'(locked),    32'd0);
        check("loss_err8",   32'(err_count), 32'd8);
        lock_up("relock");
        check("relock_err8", 32'(err_count), 32'd8);

        // Stuck-at-1 line must never lock
        do_reset();
        any_lock = 1'b0;
        for (int i = 0; i < 500; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            if (locked === 1'b1) any_lock = 1'b1;
        end
        check("stuck1_nolock", 32'(any_lock),  32'd0);
        check("stuck1_err0",   32'(err_count), 32'd0);
        check("stuck1_bit0",   32'(bit_count), 32'd0);

        // Asynchronous reset in the middle of lock
        do_reset();
        lock_up("midrst");
        repeat (5) send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        @(negedge clock);
        #2 reset = 1'b0; outstrobe = 1'b0;
        #1;
        check("midrst_locked", 32'(locked),    32'd0);
        check("midrst_de",     32'(dataerror), 32'd0);
        check("midrst_sl",     32'(sync_loss), 32'd0);
        check("midrst_err",    32'(err_count), 32'd0);
        check("midrst_bit",    32'(bit_count), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // Clear coinciding with an error strobe
        lock_up("clr");
        repeat (3) send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        check("clr_de",  32'(dataerror), 32'd1);
        check("clr_err", 32'(err_count), 32'd0);
        check("clr_bit", 32'(bit_count), 32'd0);
        send(1'b0, 1'b0);
        check("clr_bit_resume", 32'(bit_count), 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
